vga_vblank_arbiter: RTL and testbench

VGA_VBLANK_ARBITER -- requirements
Module: vga_vblank_arbiter

---
 rtl/vga_vblank_arbiter.sv | 162 ++++++++++++++++
 tb/tb_vga_vblank_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_vblank_arbiter.sv
// Grants one requester at a time access to the frame-update resource during vertical blanking.
// Each requester is served at most once per window, round-robin; timed-out or cut-off grants pulse abort.
module vga_vblank_arbiter #(
    parameter int N_REQ      = 3,
    parameter int TIMEOUT    = 1024,
    parameter int GUARD_LINE = 625
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [10:0]      vcount,
    input  logic             vblnk,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] abort,
    output logic             frame_start,
    output logic [15:0]      frame_cnt,
    output logic             in_window
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARB   = 2'd1;
    localparam logic [1:0] S_GRANT = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic             vblnk_d_reg;
    logic             frame_start_reg;
    logic [15:0]      frame_cnt_reg;
    logic [N_REQ-1:0] served_reg, served_next;
    logic [PW-1:0]    last_ptr_reg, last_ptr_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [N_REQ-1:0] gnt_reg, gnt_next;
    logic [N_REQ-1:0] abort_reg, abort_next;

    logic             rise;
    logic             past_guard;
    logic             done_hit;
    logic             timeout_hit;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] cur_onehot;
    logic [N_REQ-1:0] sel_onehot;
    logic             sel_found;
    logic [PW-1:0]    sel_idx;
    int               cand;

    assign rise        = vblnk & ~vblnk_d_reg;
    assign past_guard  = (vcount >= 11'(GUARD_LINE));
    assign pending     = req & ~served_reg;
    assign done_hit    = |(done & cur_onehot);
    assign timeout_hit = (cnt_reg == CW'(TIMEOUT - 1));

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_decode
            assign cur_onehot[gi] = (last_ptr_reg == PW'(gi));
            assign sel_onehot[gi] = (sel_idx == PW'(gi));
        end
    endgenerate

    // Search starts one past the last granted index so service rotates across windows.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = int'(last_ptr_reg) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!sel_found && pending[PW'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = PW'(cand);
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        served_next   = served_reg;
        last_ptr_next = last_ptr_reg;
        cnt_next      = cnt_reg;
        gnt_next      = gnt_reg;
        abort_next    = '0;
        if (rise) begin
            served_next = '0;
        end
        case (state_reg)
            S_IDLE: begin
                gnt_next = '0;
                if (rise) begin
                    state_next = S_ARB;
                end
            end
            S_ARB: begin
                gnt_next = '0;
                if (!vblnk) begin
                    state_next = S_IDLE;
                end else if (sel_found && !past_guard) begin
                    last_ptr_next = sel_idx;
                    cnt_next      = '0;
                    gnt_next      = sel_onehot;
                    state_next    = S_GRANT;
                end
            end
            S_GRANT: begin
                cnt_next = cnt_reg + CW'(1);
                // A done arriving with a timeout or a vblank fall still counts as completion.
                if (done_hit) begin
                    served_next = served_reg | cur_onehot;
                    gnt_next    = '0;
                    state_next  = vblnk ? S_ARB : S_IDLE;
                end else if (!vblnk) begin
                    abort_next = cur_onehot;
                    gnt_next   = '0;
                    state_next = S_IDLE;
                end else if (timeout_hit) begin
                    abort_next  = cur_onehot;
                    served_next = served_reg | cur_onehot;
                    gnt_next    = '0;
                    state_next  = S_ARB;
                end
            end
            default: begin
                gnt_next   = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            vblnk_d_reg     <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_cnt_reg   <= '0;
            served_reg      <= '0;
            last_ptr_reg    <= PW'(N_REQ - 1);
            cnt_reg         <= '0;
            gnt_reg         <= '0;
            abort_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            vblnk_d_reg     <= vblnk;
            frame_start_reg <= rise;
            frame_cnt_reg   <= frame_cnt_reg + {15'd0, rise};
            served_reg      <= served_next;
            last_ptr_reg    <= last_ptr_next;
            cnt_reg         <= cnt_next;
            gnt_reg         <= gnt_next;
            abort_reg       <= abort_next;
        end
    end

    assign gnt         = gnt_reg;
    assign abort       = abort_reg;
    assign frame_start = frame_start_reg;
    assign frame_cnt   = frame_cnt_reg;
    assign in_window   = (state_reg != S_IDLE);

endmodule

// File: tb/tb_vga_vblank_arbiter.sv
// Scenario bench for vga_vblank_arbiter: expected grant/abort events are queued by each
// scenario and matched in order by a monitor as the DUT produces them.
module tb_vga_vblank_arbiter;

    logic        pclk;
    logic        rst;
    logic [10:0] vcount;
    logic        vblnk;
    logic [2:0]  req;
    logic [2:0]  done;
    logic [2:0]  gnt;
    logic [2:0]  abort;
    logic        frame_start;
    logic [15:0] frame_cnt;
    logic        in_window;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_fc  = 16'd0;
    logic [3:0]  exp_q[$];
    logic [2:0]  gnt_prev = 3'b000;
    logic [3:0]  mon_ev;
    logic [3:0]  mon_exp;

    vga_vblank_arbiter #(
        .N_REQ     (3),
        .TIMEOUT   (16),
        .GUARD_LINE(625)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .vcount     (vcount),
        .vblnk      (vblnk),
        .req        (req),
        .done       (done),
        .gnt        (gnt),
        .abort      (abort),
        .frame_start(frame_start),
        .frame_cnt  (frame_cnt),
        .in_window  (in_window)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Event monitor: {0,gnt} when a grant starts, {1,abort} on every abort pulse.
    always @(negedge pclk) begin
        n_tests++;
        if ($countones(gnt) > 1 || (gnt & abort) != 3'b000) begin
            n_fail++;
            $display("FAIL grant_invariant: gnt=%b abort=%b required one-hot gnt disjoint from abort", gnt, abort);
        end
        if (gnt != 3'b000 && gnt_prev == 3'b000) begin
            mon_ev = {1'b0, gnt};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got grant %b required no event", gnt);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_ev !== mon_exp) begin
                    n_fail++;
                    $display("FAIL event_order: got %b required %b (msb=1 abort)", mon_ev, mon_exp);
                end
            end
        end
        if (abort != 3'b000) begin
            mon_ev = {1'b1, abort};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got abort %b required no event", abort);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_ev !== mon_exp) begin
                    n_fail++;
                    $display("FAIL event_order: got %b required %b (msb=1 abort)", mon_ev, mon_exp);
                end
            end
        end
        gnt_prev = gnt;
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic open_window(input logic [10:0] vc, input logic [2:0] r);
        vcount = vc;
        req    = r;
        vblnk  = 1'b1;
        exp_fc = exp_fc + 16'd1;
        step();
    endtask

    task automatic close_window();
        vblnk = 1'b0;
        req   = 3'b000;
        done  = 3'b000;
        step();
        step();
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge pclk);
            if (gnt != 3'b000) ok = 1'b1;
        end
    endtask

    task automatic finish_grant(input int delay);
        repeat (delay) step();
        done = gnt;
        step();
        done = 3'b000;
    endtask

    task automatic test_reset();
        rst = 1'b1; vblnk = 1'b1; req = 3'b000; done = 3'b000; vcount = 11'd0;
        repeat (3) step();
        n_tests += 5;
        if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b required 000", gnt); end
        if (abort !== 3'b000) begin n_fail++; $display("FAIL reset_abort: got %b required 000", abort); end
        if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %b required 0", frame_start); end
        if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt); end
        if (in_window !== 1'b0) begin n_fail++; $display("FAIL reset_in_window: got %b required 0", in_window); end
        // vblnk already high at release must register as a rise
        rst = 1'b0;
        exp_fc = 16'd1;
        step();
        n_tests += 3;
        if (frame_start !== 1'b1) begin n_fail++; $display("FAIL release_frame_start: got %b required 1", frame_start); end
        if (frame_cnt !== exp_fc) begin n_fail++; $display("FAIL release_frame_cnt: got %0d required %0d", frame_cnt, exp_fc); end
        if (in_window !== 1'b1) begin n_fail++; $display("FAIL release_in_window: got %b required 1", in_window); end
        step();
        n_tests++;
        if (frame_start !== 1'b0) begin n_fail++; $display("FAIL frame_start_width: got %b required 0", frame_start); end
        close_window();
        n_tests++;
        if (in_window !== 1'b0) begin n_fail++; $display("FAIL release_close: got %b required 0", in_window); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_round_robin();
        bit ok;
        open_window(11'd0, 3'b111);
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
        for (int i = 0; i < 3; i++) begin
            wait_gnt(ok);
            n_tests++;
            if (!ok) begin n_fail++; $display("FAIL rr_wait_grant%0d: got timeout required grant", i); end
            else finish_grant(10);
        end
        repeat (5) step();
        n_tests += 3;
        if (frame_cnt !== exp_fc) begin n_fail++; $display("FAIL rr_frame_cnt: got %0d required %0d", frame_cnt, exp_fc); end
        if (in_window !== 1'b1) begin n_fail++; $display("FAIL rr_in_window: got %b required 1", in_window); end
        if (gnt !== 3'b000) begin n_fail++; $display("FAIL rr_all_served: got %b required 000", gnt); end
        close_window();
        n_tests += 2;
        if (in_window !== 1'b0) begin n_fail++; $display("FAIL rr_close: got %b required 0", in_window); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_events_left: got %0d required 0", exp_q.size()); end
        $display("[TB] test_round_robin done");
    endtask

    task automatic test_rr_continue();
        bit ok;
        logic [2:0] win_req[3] = '{3'b011, 3'b011, 3'b110};
        // third window starts after index 1, so index 2 precedes index 1
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100); exp_q.push_back(4'b0010);
        for (int w = 0; w < 3; w++) begin
            open_window(11'd0, win_req[w]);
            for (int i = 0; i < 2; i++) begin
                wait_gnt(ok);
                n_tests++;
                if (!ok) begin n_fail++; $display("FAIL rrc_wait_grant w%0d g%0d: got timeout required grant", w, i); end
                else finish_grant(3);
            end
            repeat (3) step();
            close_window();
        end
        n_tests += 2;
        if (frame_cnt !== exp_fc) begin n_fail++; $display("FAIL rrc_frame_cnt: got %0d required %0d", frame_cnt, exp_fc); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rrc_events_left: got %0d required 0", exp_q.size()); end
        $display("[TB] test_rr_continue done");
    endtask

    task automatic test_timeout();
        bit ok;
        int cnt;
        open_window(11'd0, 3'b100);
        exp_q.push_back(4'b0100); exp_q.push_back(4'b1100);
        wait_gnt(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL to_wait_grant: got timeout required grant"); end
        cnt = 0;
        while (gnt == 3'b100 && cnt < 40) begin
            cnt++;
            @(negedge pclk);
        end
        n_tests += 3;
        if (cnt != 16) begin n_fail++; $display("FAIL to_grant_len: got %0d required 16", cnt); end
        if (abort !== 3'b100) begin n_fail++; $display("FAIL to_abort: got %b required 100", abort); end
        if (gnt !== 3'b000) begin n_fail++; $display("FAIL to_gnt_drop: got %b required 000", gnt); end
        @(negedge pclk);
        n_tests++;
        if (abort !== 3'b000) begin n_fail++; $display("FAIL to_abort_width: got %b required 000", abort); end
        repeat (20) step();
        n_tests += 3;
        if (gnt !== 3'b000) begin n_fail++; $display("FAIL to_no_regrant: got %b required 000", gnt); end
        if (in_window !== 1'b1) begin n_fail++; $display("FAIL to_in_window: got %b required 1", in_window); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL to_events_left: got %0d required 0", exp_q.size()); end
        close_window();
        $display("[TB] test_timeout done");
    endtask

    task automatic test_vblank_fall();
        bit ok;
        open_window(11'd0, 3'b001);
        exp_q.push_back(4'b0001); exp_q.push_back(4'b1001);
        wait_gnt(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL vf_wait_grant: got timeout required grant"); end
        step();
        vblnk = 1'b0;
        step();
        n_tests += 3;
        if (gnt !== 3'b000) begin n_fail++; $display("FAIL vf_gnt: got %b required 000", gnt); end
        if (abort !== 3'b001) begin n_fail++; $display("FAIL vf_abort: got %b required 001", abort); end
        if (in_window !== 1'b0) begin n_fail++; $display("FAIL vf_in_window: got %b required 0", in_window); end
        req = 3'b000;
        step();
        // done in the same cycle as the fall is a completion
        open_window(11'd0, 3'b001);
        exp_q.push_back(4'b0001);
        wait_gnt(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL vfd_wait_grant: got timeout required grant"); end
        step();
        vblnk = 1'b0;
        done  = 3'b001;
        step();
        done = 3'b000;
        n_tests += 3;
        if (abort !== 3'b000) begin n_fail++; $display("FAIL vfd_abort: got %b required 000", abort); end
        if (gnt !== 3'b000) begin n_fail++; $display("FAIL vfd_gnt: got %b required 000", gnt); end
        if (in_window !== 1'b0) begin n_fail++; $display("FAIL vfd_in_window: got %b required 0", in_window); end
        close_window();
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL vf_events_left: got %0d required 0", exp_q.size()); end
        $display("[TB] test_vblank_fall done");
    endtask

    task automatic test_ignore();
        bit ok;
        open_window(11'd0, 3'b011);
        exp_q.push_back(4'b0010); exp_q.push_back(4'b0001);
        wait_gnt(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL ig_wait_grant: got timeout required grant"); end
        step();
        done = 3'b001;
        step();
        done = 3'b000;
        req  = 3'b000;
        repeat (3) step();
        n_tests += 2;
        if (gnt !== 3'b010) begin n_fail++; $display("FAIL ig_gnt_held: got %b required 010", gnt); end
        if (abort !== 3'b000) begin n_fail++; $display("FAIL ig_abort: got %b required 000", abort); end
        done = 3'b010;
        step();
        done = 3'b000;
        req  = 3'b001;
        wait_gnt(ok);
        n_tests += 2;
        if (!ok) begin n_fail++; $display("FAIL ig_wait_grant2: got timeout required grant"); end
        if (gnt !== 3'b001) begin n_fail++; $display("FAIL ig_second_gnt: got %b required 001", gnt); end
        finish_grant(2);
        close_window();
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL ig_events_left: got %0d required 0", exp_q.size()); end
        $display("[TB] test_ignore done");
    endtask

    task automatic test_guard();
        bit ok;
        logic [10:0] lines[3] = '{11'd626, 11'd625, 11'd624};
        for (int i = 0; i < 3; i++) begin
            open_window(lines[i], 3'b010);
            if (lines[i] < 11'd625) begin
                exp_q.push_back(4'b0010);
                wait_gnt(ok);
                n_tests++;
                if (!ok) begin n_fail++; $display("FAIL guard_grant vcount=%0d: got timeout required grant", lines[i]); end
                else finish_grant(3);
            end else begin
                repeat (10) step();
                n_tests += 2;
                if (gnt !== 3'b000) begin n_fail++; $display("FAIL guard_block vcount=%0d: got %b required 000", lines[i], gnt); end
                if (in_window !== 1'b1) begin n_fail++; $display("FAIL guard_in_window vcount=%0d: got %b required 1", lines[i], in_window); end
            end
            close_window();
        end
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL guard_events_left: got %0d required 0", exp_q.size()); end
        $display("[TB] test_guard done");
    endtask

    task automatic test_reset_mid_grant();
        bit ok;
        open_window(11'd0, 3'b010);
        exp_q.push_back(4'b0010);
        wait_gnt(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL rmg_wait_grant: got timeout required grant"); end
        step();
        rst = 1'b1; vblnk = 1'b0; req = 3'b000;
        step();
        n_tests += 5;
        if (gnt !== 3'b000) begin n_fail++; $display("FAIL rmg_gnt: got %b required 000", gnt); end
        if (abort !== 3'b000) begin n_fail++; $display("FAIL rmg_abort: got %b required 000", abort); end
        if (frame_start !== 1'b0) begin n_fail++; $display("FAIL rmg_frame_start: got %b required 0", frame_start); end
        if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rmg_frame_cnt: got %0d required 0", frame_cnt); end
        if (in_window !== 1'b0) begin n_fail++; $display("FAIL rmg_in_window: got %b required 0", in_window); end
        rst = 1'b0;
        exp_fc = 16'd0;
        step();
        n_tests++;
        if (abort !== 3'b000) begin n_fail++; $display("FAIL rmg_abort_after: got %b required 000", abort); end
        // pointer back at 2, so index 0 wins first
        open_window(11'd0, 3'b111);
        exp_q.push_back(4'b0001);
        wait_gnt(ok);
        n_tests += 2;
        if (!ok) begin n_fail++; $display("FAIL rmg_wait_grant2: got timeout required grant"); end
        if (gnt !== 3'b001) begin n_fail++; $display("FAIL rmg_first_after_reset: got %b required 001", gnt); end
        finish_grant(2);
        close_window();
        n_tests++;
        if (frame_cnt !== exp_fc) begin n_fail++; $display("FAIL rmg_frame_cnt_after: got %0d required %0d", frame_cnt, exp_fc); end
        $display("[TB] test_reset_mid_grant done");
    endtask

    task automatic test_frame_wrap();
        // jump the counter near its top instead of running 65534 frames
        @(negedge pclk);
        force dut.frame_cnt_reg = 16'hFFFE;
        #1;
        release dut.frame_cnt_reg;
        exp_fc = 16'hFFFE;
        req = 3'b000;
        for (int i = 0; i < 3; i++) begin
            vblnk  = 1'b1;
            exp_fc = exp_fc + 16'd1;
            step();
            n_tests += 2;
            if (frame_cnt !== exp_fc) begin n_fail++; $display("FAIL wrap_frame_cnt%0d: got %h required %h", i, frame_cnt, exp_fc); end
            if (frame_start !== 1'b1) begin n_fail++; $display("FAIL wrap_frame_start%0d: got %b required 1", i, frame_start); end
            vblnk = 1'b0;
            step();
            step();
        end
        $display("[TB] test_frame_wrap done");
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_rr_continue();
        test_timeout();
        test_vblank_fall();
        test_ignore();
        test_guard();
        test_reset_mid_grant();
        test_frame_wrap();
        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
